filter_cfg_sequencer: RTL

Command decoder and configuration controller sitting behind the Pico handshake receiver. It consumes the receiver's nibble stream (data plus one-cycle new-data pulse) and assembles framed commands. It drives the filter core's coefficient write port and the enable/bypass controls. It guards coefficient writes, detects malformed frames and times out stalled frames.

---
 rtl/filter_cfg_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/filter_cfg_sequencer.sv
// Command decoder behind the nibble receiver: assembles framed commands, drives the
// filter core's coefficient write port and enable/bypass levels, and flags bad frames.
module filter_cfg_sequencer #(
  parameter int DATA_WIDTH     = 4,
  parameter int NUM_COEFS      = 8,
  parameter int COEF_NIBBLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int AW = (NUM_COEFS > 1) ? $clog2(NUM_COEFS) : 1,
  localparam int CW = COEF_NIBBLES * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // Receiver side: nib_valid is a one-cycle strobe with no ready; every strobe is
  // consumed in the cycle it arrives, so back-to-back strobes are never dropped.
  input  logic [DATA_WIDTH-1:0] nib_data,
  input  logic                  nib_valid,
  output logic                  coef_wr_en,
  output logic [AW-1:0]         coef_wr_addr,
  output logic [CW-1:0]         coef_wr_data,
  output logic                  filter_enable,
  output logic                  filter_bypass,
  output logic                  cfg_busy,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [1:0]            state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int NW = (COEF_NIBBLES > 1) ? $clog2(COEF_NIBBLES) : 1;

  localparam logic [DATA_WIDTH-1:0] OP_NOP        = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] OP_WRITE_COEF = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OP_ENABLE     = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] OP_DISABLE    = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] OP_BYPASS_ON  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] OP_BYPASS_OFF = DATA_WIDTH'(5);

  localparam logic [1:0] ERR_ILLEGAL_OP = 2'd0;
  localparam logic [1:0] ERR_BAD_ADDR   = 2'd1;
  localparam logic [1:0] ERR_LOCKED     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_COEF = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [NW-1:0]   nib_cnt_q, nib_cnt_d;
  logic [CW-1:0]   shift_q, shift_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            perr_q, perr_d;
  logic [1:0]      pcode_q, pcode_d;
  logic            wr_en_d;
  logic [AW-1:0]   wr_addr_d;
  logic [CW-1:0]   wr_data_d;
  logic            enable_d, bypass_d;
  logic            err_pulse_d;
  logic [1:0]      err_code_d;

  logic            addr_bad;
  logic            tmo_hit;
  logic            last_nib;
  logic [CW-1:0]   shift_next;

  assign addr_bad   = ({1'b0, nib_data} >= (DATA_WIDTH + 1)'(NUM_COEFS));
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign last_nib   = (nib_cnt_q == NW'(COEF_NIBBLES - 1));
  assign shift_next = (shift_q << DATA_WIDTH) | CW'(nib_data);

  assign cfg_busy  = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    nib_cnt_d   = nib_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    perr_d      = perr_q;
    pcode_d     = pcode_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = coef_wr_addr;
    wr_data_d   = coef_wr_data;
    enable_d    = filter_enable;
    bypass_d    = filter_bypass;
    err_pulse_d = 1'b0;
    err_code_d  = err_code;

    case (state_q)
      IDLE: begin
        tmo_d     = '0;
        nib_cnt_d = '0;
        if (nib_valid) begin
          case (nib_data)
            OP_NOP:        ;
            OP_WRITE_COEF: state_d  = GET_ADDR;
            OP_ENABLE:     enable_d = 1'b1;
            OP_DISABLE:    enable_d = 1'b0;
            OP_BYPASS_ON:  bypass_d = 1'b1;
            OP_BYPASS_OFF: bypass_d = 1'b0;
            default: begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_ILLEGAL_OP;
            end
          endcase
        end
      end

      GET_ADDR, GET_COEF: begin
        if (nib_valid) begin
          tmo_d = '0;
          if (state_q == GET_ADDR) begin
            // Address problems are remembered and reported only once the frame ends.
            addr_d    = nib_data[AW-1:0];
            perr_d    = addr_bad || filter_enable;
            pcode_d   = addr_bad ? ERR_BAD_ADDR : ERR_LOCKED;
            shift_d   = '0;
            nib_cnt_d = '0;
            state_d   = GET_COEF;
          end else begin
            shift_d = shift_next;
            if (last_nib) begin
              state_d   = IDLE;
              nib_cnt_d = '0;
              if (perr_q) begin
                err_pulse_d = 1'b1;
                err_code_d  = pcode_q;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = shift_next;
              end
            end else begin
              nib_cnt_d = nib_cnt_q + NW'(1);
            end
          end
        end else if (tmo_hit) begin
          state_d     = IDLE;
          tmo_d       = '0;
          nib_cnt_d   = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      nib_cnt_q     <= '0;
      shift_q       <= '0;
      addr_q        <= '0;
      perr_q        <= 1'b0;
      pcode_q       <= 2'd0;
      coef_wr_en    <= 1'b0;
      coef_wr_addr  <= '0;
      coef_wr_data  <= '0;
      filter_enable <= 1'b0;
      filter_bypass <= 1'b0;
      err_pulse     <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      nib_cnt_q     <= nib_cnt_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      perr_q        <= perr_d;
      pcode_q       <= pcode_d;
      coef_wr_en    <= wr_en_d;
      coef_wr_addr  <= wr_addr_d;
      coef_wr_data  <= wr_data_d;
      filter_enable <= enable_d;
      filter_bypass <= bypass_d;
      err_pulse     <= err_pulse_d;
      err_code      <= err_code_d;
    end
  end

endmodule
